arb_rr4: RTL and testbench
==========================

ARB_RR4 -- requirements
Module: arb_rr4

Interface
REQ-001 SHALL have parameter DW, default 2, the operand/result data width.
REQ-002 SHALL have parameter NREQ, fixed at 4, the number of requesters; other values are unsupported.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  4  per-requester request; req[i] high means requester i has a pending operand.
REQ-006 d0, d1, d2, d3  input  DW each  operand of requesters 0..3.
REQ-007 out_ready  input  1  downstream accept.
REQ-008 gnt  output  4  one-hot grant to the current winner; all zero when idle.
REQ-009 sel  output  2  binary winner code, driving the downstream 4:1 select.
REQ-010 out_valid  output  1  out_data and sel are valid.
REQ-011 out_data  output  DW  registered copy of the winner's operand.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-013 SHALL keep a 2-bit priority pointer ptr: the requester index scanned first.
REQ-014 Pick rule: first i with req[i]=1 in the order ptr, ptr+1, ptr+2, ptr+3, taken mod 4 (3 wraps to 0).
REQ-015 IDLE, req==0: SHALL stay IDLE with outputs unchanged (gnt=0, out_valid=0).
REQ-016 IDLE, req!=0: on the next edge SHALL register winner w into sel, set gnt[w], capture d_w into out_data, set out_valid and enter BUSY; latency is exactly 1 cycle.
REQ-017 BUSY, out_ready=0: sel, gnt, out_data and out_valid SHALL hold stable; changes on d0..d3 or req SHALL have no effect.
REQ-018 BUSY, out_ready=1 (handshake): SHALL set ptr to (w+1) mod 4.
REQ-019 Same handshake cycle: SHALL re-arbitrate req with bit w masked, scanning from (w+1) mod 4.
REQ-020 If that masked request set is non-zero: SHALL register the new winner, gnt, sel and data and stay BUSY (back-to-back, no idle bubble).
REQ-021 Otherwise: SHALL clear gnt and out_valid and enter IDLE; sel and out_data hold their last values.
REQ-022 A winner dropping req while in BUSY SHALL NOT abort the transaction; it completes on handshake.
REQ-023 A requester holding req continuously SHALL receive at most one grant per round while any other requester is requesting. Worst-case wait is 3 transactions.
REQ-024 gnt SHALL be one-hot or zero at all times.
REQ-025 gnt[sel] SHALL equal 1 whenever out_valid=1.
REQ-026 out_valid SHALL be 1 exactly when state is BUSY.
REQ-027 out_ready while IDLE SHALL be ignored.

Reset
REQ-028 While rst=1 at an edge: SHALL force state=IDLE, ptr=0, gnt=0, sel=0, out_valid=0 and out_data=0.
REQ-029 Reset asserted in BUSY SHALL abandon the pending transaction without a handshake.
REQ-030 Reset SHALL take priority over the handshake and over arbitration in the same cycle.
REQ-031 In the first cycle after rst deasserts, the block SHALL arbitrate normally from ptr=0.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, BUSY), the constant NREQ=4 and the 2-bit requester-index typedef.
REQ-033 SHALL contain one combinational sub-module, rr_pick4, which:
- takes inputs req(4), mask(4) and ptr(2);
- returns winner(2) and any(1).
REQ-034 Operand selection SHALL be a 4:1 mux of d0..d3 indexed by the winner code, feeding the out_data register.

Verification
REQ-035 Reset then req=4'b0000 for 5 cycles -> gnt=0, out_valid=0, sel=0, out_data=0 throughout.
REQ-036 req=4'b1111 held, out_ready=1, d0..d3=0,1,2,3 -> sel sequence 0,1,2,3,0; out_data 0,1,2,3,0; out_valid continuously 1.
REQ-037 Single grant with stalled output:
- Stimulus: req=4'b0100, d2=2'b10, out_ready=0 for 4 cycles, d2 changed to 2'b01 mid-stall, then out_ready=1.
- Required response: gnt=4'b0100, sel=2 and out_data=2'b10 stable through the stall; IDLE the cycle after the handshake.
REQ-038 Wrap-around:
- Stimulus: ptr=3 (after serving requester 2), then req=4'b1001.
- Required response: requester 3 granted first, then requester 0.
REQ-039 Winner drop and mid-stall reset:
- Stimulus: winner drops req during the stall; then rst=1 asserted during BUSY.
- Required response: the transaction completes on out_ready for the drop; for the reset, the next cycle shows out_valid=0, gnt=0, and ptr=0 (verified by req=4'b1111 granting 0 first).

Source files
------------

// File: rtl/arb_rr4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package arb_rr4_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef logic [1:0] req_idx_t;

  function automatic logic [NREQ-1:0] idx_onehot(input req_idx_t idx);
    return 4'b0001 << idx;
  endfunction

  function automatic req_idx_t idx_next(input req_idx_t idx);
    return req_idx_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first unmasked request at or after ptr.
module rr_pick4
  import arb_rr4_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  req_idx_t        ptr,
  output req_idx_t        winner,
  output logic            any
);

  logic [NREQ-1:0]   w_live;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  req_idx_t          w_off;

  // Rotate the live requests so bit 0 is the pointer position, then priority-encode.
  always_comb begin
    w_live = req & ~mask;
    w_dbl  = {w_live, w_live};
    w_rot  = w_dbl[ptr +: NREQ];
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_off = 2'd0;
    endcase
    winner = req_idx_t'(ptr + w_off);
    any    = |w_live;
  end

endmodule

// File: rtl/arb_rr4.sv
// Four-requester round-robin arbiter with a registered operand output and
// a valid/ready handshake; supports back-to-back grants without idle cycles.
module arb_rr4
  import arb_rr4_pkg::*;
#(
  parameter int DW   = 2,
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [DW-1:0]   d0,
  input  logic [DW-1:0]   d1,
  input  logic [DW-1:0]   d2,
  input  logic [DW-1:0]   d3,
  input  logic            out_ready,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            out_valid,
  output logic [DW-1:0]   out_data
);

  state_t          r_state;
  req_idx_t        r_ptr;
  req_idx_t        r_sel;
  logic [NREQ-1:0] r_gnt;
  logic            r_valid;
  logic [DW-1:0]   r_data;

  logic [NREQ-1:0] w_mask;
  req_idx_t        w_scan;
  req_idx_t        w_winner;
  logic            w_any;
  logic [DW-1:0]   w_operand;

  // In BUSY the picker is only consulted on a handshake, so scan from the
  // slot after the current winner with that winner masked out.
  always_comb begin
    w_mask = 4'b0000;
    w_scan = r_ptr;
    if (r_state == ST_BUSY) begin
      w_mask = idx_onehot(r_sel);
      w_scan = idx_next(r_sel);
    end else begin
      w_mask = 4'b0000;
      w_scan = r_ptr;
    end
  end

  rr_pick4 u_pick (
    .req    (req),
    .mask   (w_mask),
    .ptr    (w_scan),
    .winner (w_winner),
    .any    (w_any)
  );

  // 4:1 operand select driven by the candidate winner.
  always_comb begin
    w_operand = '0;
    case (w_winner)
      2'd0:    w_operand = d0;
      2'd1:    w_operand = d1;
      2'd2:    w_operand = d2;
      2'd3:    w_operand = d3;
      default: w_operand = '0;
    endcase
  end

  // Arbiter FSM; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_BUSY;
            r_sel   <= w_winner;
            r_gnt   <= idx_onehot(w_winner);
            r_data  <= w_operand;
            r_valid <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (out_ready) begin
            r_ptr <= idx_next(r_sel);
            if (w_any) begin
              r_sel   <= w_winner;
              r_gnt   <= idx_onehot(w_winner);
              r_data  <= w_operand;
              r_valid <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= 4'b0000;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 4'b0000;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule

// File: tb/tb_arb_rr4.sv
// Randomised and directed bench for arb_rr4 against a cycle-level reference model.
module tb_arb_rr4;

  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] d0, d1, d2, d3;
  logic          out_ready;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          out_valid;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  arb_rr4 #(.DW(DW), .NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit            m_busy = 1'b0;
  int            m_ptr  = 0;
  int            m_w    = 0;
  logic [DW-1:0] m_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] operand(input int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  task automatic model_step();
    logic [3:0] rest;
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_w = 0; m_data = '0;
    end else if (!m_busy) begin
      if (req != 4'b0000) begin
        m_w = pick(req, m_ptr); m_data = operand(m_w); m_busy = 1'b1;
      end
    end else if (out_ready) begin
      m_ptr = (m_w + 1) % 4;
      rest = req;
      rest[m_w] = 1'b0;
      if (rest != 4'b0000) begin
        m_w = pick(rest, m_ptr); m_data = operand(m_w);
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic step(input string tag);
    logic [3:0] exp_gnt;
    @(posedge clk);
    model_step();
    #1;
    exp_gnt = m_busy ? (4'b0001 << m_w) : 4'b0000;
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, ".sel"}, 32'(sel), 32'(m_w));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_busy));
    chk({tag, ".data"}, 32'(out_data), 32'(m_data));
    chk({tag, ".onehot0"}, 32'($onehot0(gnt)), 32'd1);
    chk({tag, ".gnt_sel"}, 32'(out_valid ? gnt[sel] : 1'b1), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    step("reset");
    step("reset");

    // idle with no requests
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("idle");
      chk("idle.data0", 32'(out_data), 32'd0);
    end

    // full rotation with everyone requesting
    d0 = 2'd0; d1 = 2'd1; d2 = 2'd2; d3 = 2'd3;
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("rr");
      chk("rr.seq_sel", 32'(sel), 32'(i % 4));
      chk("rr.seq_data", 32'(out_data), 32'(i % 4));
      chk("rr.seq_valid", 32'(out_valid), 32'd1);
    end
    req = 4'b0000;
    step("rr_drain");

    // single grant held through a stall; operand change must not leak
    req = 4'b0100; d2 = 2'b10; out_ready = 1'b0;
    step("stall_grant");
    for (int i = 0; i < 4; i++) begin
      if (i == 2) d2 = 2'b01;
      step("stall");
      chk("stall.gnt", 32'(gnt), 32'h4);
      chk("stall.sel", 32'(sel), 32'd2);
      chk("stall.data", 32'(out_data), 32'h2);
    end
    out_ready = 1'b1;
    step("stall_hs");
    chk("stall_hs.idle", 32'(out_valid), 32'd0);
    req = 4'b0000;
    step("stall_after");

    // wrap-around: pointer sits at 3 after serving requester 2
    req = 4'b1001; out_ready = 1'b1;
    step("wrap1");
    chk("wrap.first", 32'(sel), 32'd3);
    step("wrap2");
    chk("wrap.second", 32'(sel), 32'd0);
    req = 4'b0000;
    step("wrap_drain");

    // winner drops its request mid-stall
    req = 4'b0010; out_ready = 1'b0;
    step("drop_grant");
    req = 4'b0000;
    step("drop_stall");
    step("drop_stall");
    chk("drop.held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step("drop_hs");
    chk("drop.done", 32'(out_valid), 32'd0);

    // reset while busy
    req = 4'b0100; out_ready = 1'b0;
    step("rbusy_grant");
    rst = 1'b1; out_ready = 1'b1;
    step("rbusy_rst");
    chk("rbusy.valid", 32'(out_valid), 32'd0);
    chk("rbusy.gnt", 32'(gnt), 32'd0);
    rst = 1'b0; req = 4'b1111; out_ready = 1'b0;
    step("rbusy_after");
    chk("rbusy.ptr0", 32'(sel), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      req       = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 63) == 0);
      d0 = DW'($urandom); d1 = DW'($urandom);
      d2 = DW'($urandom); d3 = DW'($urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
